// File: rtl/aes_visc_pkg.sv
// Shared types, round constants and S-box for the VISC AES-128 pipeline stages.
package aes_visc_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned N_RK    = 6;

    typedef logic [BYTE_W-1:0]  byte_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_ROUND,
        S_HOLD
    } state_t;

    localparam byte_t RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic byte_t sbox(input byte_t b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column, row 0 in the top byte.
    function automatic word_t mix_column(input word_t col);
        byte_t a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 key-schedule step: previous round key plus RCON byte to the next round key.
module aes_key_expand_step
    import aes_visc_pkg::*;
(
    input  logic [127:0] prev_key_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] next_key_c_o
);

    word_t w0, w1, w2, w3;
    word_t n0, n1, n2, n3;
    word_t t;

    assign {w0, w1, w2, w3} = prev_key_i;

    // RotWord then SubWord on the last word, RCON folded into the top byte.
    assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_i, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key_c_o = {n0, n1, n2, n3};

endmodule

// File: rtl/round_visc.sv
// One full AES encryption round (SubBytes, ShiftRows, MixColumns, AddRoundKey) with a registered result.
module round_visc
    import aes_visc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    output logic [127:0] state_o
);

    byte_t  sb [16];
    byte_t  sr [16];
    block_t mixed;
    block_t state_q;

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb[i] = sbox(state_i[127-8*i -: 8]);
    end

    // Byte index is row + 4*column; row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[r+4*c] = sb[r + 4*((c + r) % 4)];
        end
        assign mixed[127-32*c -: 32] = mix_column({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= mixed ^ round_key_i;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/aes_stage_one_visc.sv
// Front stage of the VISC AES-128 pipeline: whitening, round 1 and round keys 1-5.
// Optional key cache enabled by defining AES_VISC_KEY_CACHE_EN.
module aes_stage_one_visc
    import aes_visc_pkg::*;
#(
    parameter int unsigned KEY_CACHE_DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext_in,
    input  logic [127:0] key_in,
    output logic [127:0] data_out,
    output logic [127:0] key_s2,
    output logic [127:0] key_s3,
    output logic [127:0] key_s4,
    output logic [127:0] key_s5,
    output logic         ready_out,
    input  logic         done_in
);

    if (KEY_CACHE_DEPTH != 1) begin : g_depth_check
        $error("aes_stage_one_visc: KEY_CACHE_DEPTH must be 1");
    end

    state_t     state_q;
    logic [2:0] cnt_q;
    block_t     state0_q;
    block_t     rk_q [N_RK];
    block_t     round_out;
    block_t     exp_prev;
    byte_t      exp_rcon;
    block_t     exp_next;

`ifdef AES_VISC_KEY_CACHE_EN
    block_t     cache_key_q;
    logic       cache_vld_q;
    logic       hit_wait_q;
`endif

    // Round 1 always sees the whitened state and rk1; its output is only sampled in S_ROUND.
    round_visc u_round1 (
        .clk         (clk),
        .rst         (rst),
        .state_i     (state0_q),
        .round_key_i (rk_q[1]),
        .state_o     (round_out)
    );

    // Counter selects which stored key feeds the single expansion step.
    always_comb begin
        exp_prev = rk_q[0];
        exp_rcon = RCON[1];
        case (cnt_q)
            3'd2: begin exp_prev = rk_q[1]; exp_rcon = RCON[2]; end
            3'd3: begin exp_prev = rk_q[2]; exp_rcon = RCON[3]; end
            3'd4: begin exp_prev = rk_q[3]; exp_rcon = RCON[4]; end
            3'd5: begin exp_prev = rk_q[4]; exp_rcon = RCON[5]; end
            default: ;
        endcase
    end

    aes_key_expand_step u_expand (
        .prev_key_i   (exp_prev),
        .rcon_i       (exp_rcon),
        .next_key_c_o (exp_next)
    );

    assign in_ready = (state_q == S_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            state0_q  <= '0;
            data_out  <= '0;
            ready_out <= 1'b0;
            for (int k = 0; k < N_RK; k++) begin
                rk_q[k] <= '0;
            end
`ifdef AES_VISC_KEY_CACHE_EN
            cache_key_q <= '0;
            cache_vld_q <= 1'b0;
            hit_wait_q  <= 1'b0;
`endif
        end else begin
            ready_out <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        state0_q <= plaintext_in ^ key_in;
                        rk_q[0]  <= key_in;
`ifdef AES_VISC_KEY_CACHE_EN
                        // A hit reuses rk1..rk5 but still gives round 1 a full edge.
                        if (cache_vld_q && (key_in == cache_key_q)) begin
                            hit_wait_q <= 1'b1;
                            state_q    <= S_ROUND;
                        end else begin
                            cnt_q   <= 3'd1;
                            state_q <= S_EXPAND;
                        end
`else
                        cnt_q   <= 3'd1;
                        state_q <= S_EXPAND;
`endif
                    end
                end
                S_EXPAND: begin
                    for (int k = 1; k < N_RK; k++) begin
                        if (cnt_q == 3'(k)) begin
                            rk_q[k] <= exp_next;
                        end
                    end
                    if (cnt_q == 3'd5) begin
                        cnt_q   <= 3'd0;
                        state_q <= S_ROUND;
`ifdef AES_VISC_KEY_CACHE_EN
                        cache_key_q <= rk_q[0];
                        cache_vld_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_ROUND: begin
`ifdef AES_VISC_KEY_CACHE_EN
                    if (hit_wait_q) begin
                        hit_wait_q <= 1'b0;
                    end else begin
                        data_out  <= round_out;
                        ready_out <= 1'b1;
                        state_q   <= S_HOLD;
                    end
`else
                    data_out  <= round_out;
                    ready_out <= 1'b1;
                    state_q   <= S_HOLD;
`endif
                end
                S_HOLD: begin
                    if (done_in) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign key_s2 = rk_q[2];
    assign key_s3 = rk_q[3];
    assign key_s4 = rk_q[4];
    assign key_s5 = rk_q[5];

endmodule

// File: tb/tb_aes_stage_one_visc.sv
// Directed/random bench for aes_stage_one_visc with an independent AES reference model.
module tb_aes_stage_one_visc;

`ifdef AES_VISC_KEY_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext_in;
    logic [127:0] key_in;
    logic [127:0] data_out;
    logic [127:0] key_s2, key_s3, key_s4, key_s5;
    logic         ready_out;
    logic         done_in;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] data;
        logic [127:0] k2, k3, k4, k5;
        int           lat;
    } exp_t;

    exp_t         sb_q [$];
    logic [7:0]   sb_tab [256];
    logic         cache_vld_m = 1'b0;
    logic [127:0] cache_key_m = '0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;

    aes_stage_one_visc #(.KEY_CACHE_DEPTH(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .plaintext_in (plaintext_in),
        .key_in       (key_in),
        .data_out     (data_out),
        .key_s2       (key_s2),
        .key_s3       (key_s3),
        .key_s4       (key_s4),
        .key_s5       (key_s5),
        .ready_out    (ready_out),
        .done_in      (done_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box derived from the GF(2^8) inverse and the affine map.
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
            end
            sb_tab[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic exp_t model(input logic [127:0] pt, input logic [127:0] key);
        exp_t         e;
        logic [127:0] rk [6];
        logic [31:0]  w0, w1, w2, w3, t;
        logic [7:0]   rc = 8'h01;
        logic [7:0]   b [16];
        logic [7:0]   s [16];
        logic [7:0]   m [16];
        logic [127:0] st, acc;
        rk[0] = key;
        for (int r = 1; r < 6; r++) begin
            {w0, w1, w2, w3} = rk[r-1];
            t  = {sb_tab[w3[23:16]], sb_tab[w3[15:8]], sb_tab[w3[7:0]], sb_tab[w3[31:24]]} ^ {rc, 24'h0};
            w0 = w0 ^ t;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            rk[r] = {w0, w1, w2, w3};
            rc = gmul(rc, 8'h02);
        end
        st = pt ^ key;
        for (int i = 0; i < 16; i++) b[i] = sb_tab[8'(st >> (120 - 8*i))];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r+4*c] = b[r + 4*((c + r) % 4)];
        for (int c = 0; c < 4; c++) begin
            m[4*c]   = gmul(s[4*c], 8'h02) ^ gmul(s[4*c+1], 8'h03) ^ s[4*c+2] ^ s[4*c+3];
            m[4*c+1] = s[4*c] ^ gmul(s[4*c+1], 8'h02) ^ gmul(s[4*c+2], 8'h03) ^ s[4*c+3];
            m[4*c+2] = s[4*c] ^ s[4*c+1] ^ gmul(s[4*c+2], 8'h02) ^ gmul(s[4*c+3], 8'h03);
            m[4*c+3] = gmul(s[4*c], 8'h03) ^ s[4*c+1] ^ s[4*c+2] ^ gmul(s[4*c+3], 8'h02);
        end
        acc = '0;
        for (int i = 0; i < 16; i++) acc = (acc << 8) | 128'(m[i]);
        e.data = acc ^ rk[1];
        e.k2 = rk[2];
        e.k3 = rk[3];
        e.k4 = rk[4];
        e.k5 = rk[5];
        e.lat = 7;
        return e;
    endfunction

    // Offer one block, wait for the start pulse, check it, then release after done_delay cycles.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input int done_delay);
        exp_t e;
        int   n;
        e = model(pt, key);
        e.lat = (CACHE_EN && cache_vld_m && (key == cache_key_m)) ? 3 : 7;
        sb_q.push_back(e);
        chk("in_ready_before_accept", 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        plaintext_in = pt;
        key_in = key;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!ready_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sb_q.pop_front();
        chk("ready_out_latency", 128'(n), 128'(e.lat));
        chk("data_out", data_out, e.data);
        chk("key_s2", key_s2, e.k2);
        chk("key_s3", key_s3, e.k3);
        chk("key_s4", key_s4, e.k4);
        chk("key_s5", key_s5, e.k5);
        cache_vld_m = 1'b1;
        cache_key_m = key;
        if (done_delay == 0) begin
            done_in = 1'b1;
            @(negedge clk);
            done_in = 1'b0;
            chk("ready_out_after_coincident_done", 128'(ready_out), 128'(0));
        end else begin
            @(negedge clk);
            chk("ready_out_single_pulse", 128'(ready_out), 128'(0));
            for (int i = 1; i < done_delay; i++) begin
                chk("in_ready_hold", 128'(in_ready), 128'(0));
                in_valid = 1'b1;
                plaintext_in = ~pt;
                key_in = ~key;
                @(negedge clk);
            end
            in_valid = 1'b0;
            chk("data_out_held", data_out, e.data);
            chk("key_s2_held", key_s2, e.k2);
            chk("key_s5_held", key_s5, e.k5);
            done_in = 1'b1;
            @(negedge clk);
            done_in = 1'b0;
        end
        chk("in_ready_after_done", 128'(in_ready), 128'(1));
    endtask

    initial begin
        logic [127:0] k_rand, p_rand;
        logic         seen;
        build_sbox();
        rst = 1'b1;
        in_valid = 1'b0;
        done_in = 1'b0;
        plaintext_in = '0;
        key_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 128'(in_ready), 128'(0));
        chk("reset_data_out", data_out, 128'h0);
        chk("reset_key_s2", key_s2, 128'h0);
        chk("reset_key_s5", key_s5, 128'h0);
        chk("reset_ready_out", 128'(ready_out), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 vector with a long hold and ignored input during the hold.
        run_block(FIPS_PT, FIPS_KEY, 20);
        chk("fips_data_out", data_out, 128'ha49c7ff2689f352b6b5bea43026a5049);
        chk("fips_key_s2", key_s2, 128'hf2c295f27a96b9435935807a7359f67f);
        chk("fips_key_s3", key_s3, 128'h3d80477d4716fe3e1e237e446d7a883b);
        chk("fips_key_s4", key_s4, 128'hef44a541a8525b7fb671253bdb0bad00);
        chk("fips_key_s5", key_s5, 128'hd4d1c6f87c839d87caf2b8bc11f915bc);

        // Same key again, released in the same cycle as the start pulse.
        p_rand = {$urandom, $urandom, $urandom, $urandom};
        run_block(p_rand, FIPS_KEY, 0);

        // Reset while the expansion counter is 3.
        k_rand = {$urandom, $urandom, $urandom, $urandom};
        chk("in_ready_before_abort", 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        plaintext_in = p_rand;
        key_in = k_rand;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_data_out", data_out, 128'h0);
        chk("abort_key_s2", key_s2, 128'h0);
        chk("abort_key_s3", key_s3, 128'h0);
        chk("abort_key_s4", key_s4, 128'h0);
        chk("abort_key_s5", key_s5, 128'h0);
        chk("abort_ready_out", 128'(ready_out), 128'(0));
        chk("abort_in_ready_in_reset", 128'(in_ready), 128'(0));
        rst = 1'b0;
        cache_vld_m = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ready_out) seen = 1'b1;
        end
        chk("abort_no_ready_pulse", 128'(seen), 128'(0));
        chk("abort_in_ready_idle", 128'(in_ready), 128'(1));

        // Cache was invalidated by reset: full path even for the previous key.
        run_block(FIPS_PT, FIPS_KEY, 3);

        // Random blocks with varying release delays, then a repeat of the last key.
        for (int b = 0; b < 3; b++) begin
            k_rand = {$urandom, $urandom, $urandom, $urandom};
            p_rand = {$urandom, $urandom, $urandom, $urandom};
            run_block(p_rand, k_rand, int'($urandom_range(1, 5)));
        end
        p_rand = {$urandom, $urandom, $urandom, $urandom};
        run_block(p_rand, k_rand, 2);

        chk("scoreboard_empty", 128'(sb_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
